// File: rtl/proc_multicycle.sv
// proc_multicycle: FETCH/DECODE/EXEC 16-bit-ISA core with handshaked fetch; PROC_PERF_CNT_EN adds perf counters
module proc_multicycle #(
  parameter int DATA_W = 16,
  parameter int NREGS = 8,
  parameter int RESET_PC = 0,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              wb_en,
  output logic [2:0]        wb_sel,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] pc_out,
  output logic              halted,
  output logic              err,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  localparam logic [4:0] OP_HALT = 5'b00000, OP_NOP = 5'b00001, OP_ADDI = 5'b01000,
                         OP_XOR = 5'b11011, OP_BEQZ = 5'b01100, OP_BNEZ = 5'b01101;
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  state_t state;
  logic [15:0] instr;
  logic [DATA_W-1:0] pc, rs_data, imm, rs_now, rt_now;
  logic [DATA_W-1:0] regs [NREGS];
  logic [TW-1:0] tcnt;
  logic [4:0] op;
  logic illegal, take;
  assign op = instr[15:11];
  assign imm = {{(DATA_W-5){instr[4]}}, instr[4:0]};
  assign rs_now = regs[instr[10:8]];
  assign rt_now = regs[instr[7:5]];
  assign illegal = !(op inside {OP_HALT, OP_NOP, OP_ADDI, OP_XOR, OP_BEQZ, OP_BNEZ});
  assign take = (op == OP_BEQZ && rs_data == '0) || (op == OP_BNEZ && rs_data != '0);
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign pc_out = pc;
  assign halted = state == HALT;
  // Write-back is computed in DECODE so wb_* are registered and valid throughout EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= DATA_W'(RESET_PC);
      instr <= '0;
      rs_data <= '0;
      tcnt <= '0;
      err <= 1'b0;
      wb_en <= 1'b0;
      wb_sel <= '0;
      wb_data <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            instr <= imem_rdata;
            tcnt <= '0;
            state <= DECODE;
          end else if (tcnt == TW'(FETCH_TIMEOUT - 1)) begin
            err <= 1'b1;
            state <= HALT;
          end else tcnt <= tcnt + 1'b1;
        end
        DECODE: begin
          rs_data <= rs_now;
          wb_en <= op == OP_ADDI || op == OP_XOR;
          wb_sel <= op == OP_ADDI ? instr[7:5] : instr[4:2];
          wb_data <= op == OP_ADDI ? rs_now + imm : rs_now ^ rt_now;
          state <= EXEC;
        end
        EXEC: begin
          if (wb_en) regs[wb_sel] <= wb_data;
          wb_en <= 1'b0;
          if (op == OP_HALT || illegal) begin
            err <= err | illegal;
            state <= HALT;
          end else begin
            pc <= pc + DATA_W'(2) + (take ? imm : '0);
            state <= FETCH;
          end
        end
        default: state <= HALT;
      endcase
    end
  end
`ifdef PROC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != HALT) cycle_cnt <= cycle_cnt + 1;
      if (state == EXEC && !illegal) instr_cnt <= instr_cnt + 1;
    end
  end
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif
endmodule
